nasti_lite_initiator: RTL and testbench

- Single-outstanding NASTI-Lite master that turns a simple request/response command port into AW/W/B write or AR/R read transactions.
- Drives the IO-space NASTI-Lite bus from non-core agents, e.g. a debug/boot-loader engine or a host-link command decoder, towards the UART and other IO responders.
- Sits on the initiator side of the bus, where the Rocket chip sits for core traffic.

---
 rtl/nasti_lite_pkg.sv | 26 ++
 rtl/nasti_lite_chan_reg.sv | 72 +++++++
 rtl/nasti_lite_initiator.sv | 198 +++++++++++++++++++
 tb/tb_nasti_lite_initiator.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nasti_lite_pkg.sv
// -----------------------------------------------------------------------------
// nasti_lite_pkg
// Shared definitions for the NASTI-Lite initiator: response codes, the
// transaction state encoding and the fixed protection attribute.
// -----------------------------------------------------------------------------
package nasti_lite_pkg;

    // BRESP/RRESP encodings
    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_EXOKAY = 2'd1;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'd3;

    // Unprivileged, secure, data access
    localparam logic [2:0] PROT_DEFAULT = 3'b000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_WRESP,
        ST_READ,
        ST_RDATA,
        ST_RESP
    } state_e;

endpackage

// File: rtl/nasti_lite_chan_reg.sv
// -----------------------------------------------------------------------------
// nasti_lite_chan_reg
// One-entry valid/ready hold register for an outgoing request channel.
// A load pulse captures the payload and raises valid; valid and payload stay
// stable until the handshake, after which the sticky done flag is set. The
// next load clears done.
//
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   load       capture load_data and raise valid
//   load_data  payload to hold
//   valid      channel valid (registered)
//   ready      channel ready from the responder
//   data       held payload
//   fire       handshake this cycle (valid & ready)
//   done       handshake has completed since the last load
// -----------------------------------------------------------------------------
module nasti_lite_chan_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    output logic             valid,
    input  logic             ready,
    output logic [WIDTH-1:0] data,
    output logic             fire,
    output logic             done
);

    logic             valid_q, valid_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] data_q, data_d;

    assign fire  = valid_q & ready;
    assign valid = valid_q;
    assign data  = data_q;
    assign done  = done_q;

    always_comb begin
        // NOTE: every _d gets a default first so no path leaves it unassigned (no latch).
        valid_d = valid_q;
        done_d  = done_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            done_d  = 1'b0;
            data_d  = load_data;
        end else if (fire) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state flops use non-blocking assignment so all flops update from pre-edge values.
        if (rst) begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    // NOTE: the payload is only meaningful while valid is high, so it carries no reset.
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

endmodule

// File: rtl/nasti_lite_initiator.sv
// -----------------------------------------------------------------------------
// nasti_lite_initiator
// Single-outstanding NASTI-Lite master. A request accepted on the command port
// becomes an AW+W/B write or an AR/R read; the bus response is returned on the
// response port and held until consumed.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_*                    command port (valid/ready, write, addr, wdata, strb)
//   rsp_*                    response port (valid/ready, rdata, resp)
//   nasti_aw_* / nasti_w_*   write address / write data channels
//   nasti_b_*                write response channel
//   nasti_ar_* / nasti_r_*   read address / read data channels
// -----------------------------------------------------------------------------
module nasti_lite_initiator
    import nasti_lite_pkg::*;
#(
    parameter int                  ADDR_WIDTH = 16,
    parameter int                  DATA_WIDTH = 32,
    parameter int                  ID_WIDTH   = 1,
    parameter logic [ID_WIDTH-1:0] ID_VALUE   = '0
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_strb,

    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,

    output logic                    nasti_aw_valid,
    input  logic                    nasti_aw_ready,
    output logic [ID_WIDTH-1:0]     nasti_aw_id,
    output logic [ADDR_WIDTH-1:0]   nasti_aw_addr,
    output logic [2:0]              nasti_aw_prot,

    output logic                    nasti_w_valid,
    input  logic                    nasti_w_ready,
    output logic [DATA_WIDTH-1:0]   nasti_w_data,
    output logic [DATA_WIDTH/8-1:0] nasti_w_strb,

    input  logic                    nasti_b_valid,
    output logic                    nasti_b_ready,
    input  logic [ID_WIDTH-1:0]     nasti_b_id,
    input  logic [1:0]              nasti_b_resp,

    output logic                    nasti_ar_valid,
    input  logic                    nasti_ar_ready,
    output logic [ID_WIDTH-1:0]     nasti_ar_id,
    output logic [ADDR_WIDTH-1:0]   nasti_ar_addr,
    output logic [2:0]              nasti_ar_prot,

    input  logic                    nasti_r_valid,
    output logic                    nasti_r_ready,
    input  logic [ID_WIDTH-1:0]     nasti_r_id,
    input  logic [DATA_WIDTH-1:0]   nasti_r_data,
    input  logic [1:0]              nasti_r_resp
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]            rsp_resp_q, rsp_resp_d;

    logic aw_load, w_load, ar_load;
    logic aw_fire, w_fire, ar_fire;
    logic aw_done, w_done, ar_done;

    // Only one transaction is outstanding, so returned ids carry no information.
    logic unused_ids;
    assign unused_ids = ^{nasti_b_id, nasti_r_id, ar_done};

    // ---------------------------------------------------------------- channels
    nasti_lite_chan_reg #(.WIDTH(ADDR_WIDTH)) u_aw (
        .clk       (clk),
        .rst       (rst),
        .load      (aw_load),
        .load_data (req_addr),
        .valid     (nasti_aw_valid),
        .ready     (nasti_aw_ready),
        .data      (nasti_aw_addr),
        .fire      (aw_fire),
        .done      (aw_done)
    );

    nasti_lite_chan_reg #(.WIDTH(DATA_WIDTH + STRB_WIDTH)) u_w (
        .clk       (clk),
        .rst       (rst),
        .load      (w_load),
        .load_data ({req_wdata, req_strb}),
        .valid     (nasti_w_valid),
        .ready     (nasti_w_ready),
        .data      ({nasti_w_data, nasti_w_strb}),
        .fire      (w_fire),
        .done      (w_done)
    );

    nasti_lite_chan_reg #(.WIDTH(ADDR_WIDTH)) u_ar (
        .clk       (clk),
        .rst       (rst),
        .load      (ar_load),
        .load_data (req_addr),
        .valid     (nasti_ar_valid),
        .ready     (nasti_ar_ready),
        .data      (nasti_ar_addr),
        .fire      (ar_fire),
        .done      (ar_done)
    );

    assign nasti_aw_id   = ID_VALUE;
    assign nasti_ar_id   = ID_VALUE;
    assign nasti_aw_prot = PROT_DEFAULT;
    assign nasti_ar_prot = PROT_DEFAULT;

    // ------------------------------------------------------- state decodes
    // req_ready is forced low while rst is asserted so nothing is accepted in
    // the reset cycle, whatever state the flops held before it.
    assign req_ready     = (state_q == ST_IDLE) & ~rst;
    assign nasti_b_ready = (state_q == ST_WRESP);
    assign nasti_r_ready = (state_q == ST_RDATA);
    assign rsp_valid     = (state_q == ST_RESP);
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_resp      = rsp_resp_q;

    // ------------------------------------------------------------ next state
    always_comb begin
        state_d     = state_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        aw_load     = 1'b0;
        w_load      = 1'b0;
        ar_load     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    aw_load = req_write;
                    w_load  = req_write;
                    ar_load = ~req_write;
                    state_d = req_write ? ST_WRITE : ST_READ;
                end
            end
            ST_WRITE: begin
                // A channel counts as complete if it finished earlier or fires
                // now, which covers AW-first, W-first and same-cycle orders.
                if ((aw_done | aw_fire) && (w_done | w_fire)) begin
                    state_d = ST_WRESP;
                end
            end
            ST_WRESP: begin
                if (nasti_b_valid) begin
                    rsp_resp_d  = nasti_b_resp;
                    rsp_rdata_d = '0;
                    state_d     = ST_RESP;
                end
            end
            ST_READ: begin
                if (ar_fire) begin
                    state_d = ST_RDATA;
                end
            end
            ST_RDATA: begin
                if (nasti_r_valid) begin
                    rsp_resp_d  = nasti_r_resp;
                    rsp_rdata_d = nasti_r_data;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= RESP_OKAY;
        end else begin
            state_q     <= state_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
        end
    end

endmodule

// File: tb/tb_nasti_lite_initiator.sv
// -----------------------------------------------------------------------------
// tb_nasti_lite_initiator
// Directed bench for nasti_lite_initiator. The responder side is driven
// directly by each scenario task; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_nasti_lite_initiator;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          rst;

    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [SW-1:0] req_strb;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;

    logic          aw_valid, aw_ready;
    logic [0:0]    aw_id;
    logic [AW-1:0] aw_addr;
    logic [2:0]    aw_prot;
    logic          w_valid, w_ready;
    logic [DW-1:0] w_data;
    logic [SW-1:0] w_strb;
    logic          b_valid, b_ready;
    logic [0:0]    b_id;
    logic [1:0]    b_resp;
    logic          ar_valid, ar_ready;
    logic [0:0]    ar_id;
    logic [AW-1:0] ar_addr;
    logic [2:0]    ar_prot;
    logic          r_valid, r_ready;
    logic [0:0]    r_id;
    logic [DW-1:0] r_data;
    logic [1:0]    r_resp;

    int n_vec = 0;
    int n_err = 0;

    // Handshake monitors
    int aw_hs = 0;
    int w_hs  = 0;
    int b_hs  = 0;
    int ar_hs = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (aw_valid && aw_ready) aw_hs <= aw_hs + 1;
        if (w_valid && w_ready)   w_hs  <= w_hs + 1;
        if (b_valid && b_ready)   b_hs  <= b_hs + 1;
        if (ar_valid && ar_ready) ar_hs <= ar_hs + 1;
    end

    nasti_lite_initiator #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .ID_WIDTH   (1),
        .ID_VALUE   (1'b0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_strb       (req_strb),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_rdata      (rsp_rdata),
        .rsp_resp       (rsp_resp),
        .nasti_aw_valid (aw_valid),
        .nasti_aw_ready (aw_ready),
        .nasti_aw_id    (aw_id),
        .nasti_aw_addr  (aw_addr),
        .nasti_aw_prot  (aw_prot),
        .nasti_w_valid  (w_valid),
        .nasti_w_ready  (w_ready),
        .nasti_w_data   (w_data),
        .nasti_w_strb   (w_strb),
        .nasti_b_valid  (b_valid),
        .nasti_b_ready  (b_ready),
        .nasti_b_id     (b_id),
        .nasti_b_resp   (b_resp),
        .nasti_ar_valid (ar_valid),
        .nasti_ar_ready (ar_ready),
        .nasti_ar_id    (ar_id),
        .nasti_ar_addr  (ar_addr),
        .nasti_ar_prot  (ar_prot),
        .nasti_r_valid  (r_valid),
        .nasti_r_ready  (r_ready),
        .nasti_r_id     (r_id),
        .nasti_r_data   (r_data),
        .nasti_r_resp   (r_resp)
    );

    // ---------------------------------------------------------------- helpers
    // Present a request at a falling edge, wait (bounded) for req_ready, and
    // return at the falling edge of the cycle after acceptance.
    task automatic issue(input logic wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data, input logic [SW-1:0] strb);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = data;
        req_strb  = strb;
        for (int i = 0; i < 50 && !req_ready; i++) @(negedge clk);
        n_vec++;
        if (req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL req_accept: req_ready=%b required 1", req_ready);
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Wait (bounded) for rsp_valid; lat counts cycles since acceptance,
    // assuming the caller is at the falling edge one cycle after acceptance.
    // Returns one cycle after the response was consumed (rsp_ready must be 1).
    task automatic wait_rsp(output logic [DW-1:0] rd, output logic [1:0] rs, output int lat);
        lat = 1;
        while (!rsp_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        n_vec++;
        if (rsp_valid !== 1'b1) begin
            n_err++;
            $display("FAIL rsp_timeout: rsp_valid=%b required 1", rsp_valid);
        end
        rd = rsp_rdata;
        rs = rsp_resp;
        @(negedge clk);
    endtask

    // -------------------------------------------------------------- scenarios
    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if (req_ready !== 1'b0) begin n_err++; $display("FAIL reset_req_ready: got %b required 0", req_ready); end
        n_vec++;
        if ({aw_valid, w_valid, ar_valid, b_ready, r_ready, rsp_valid} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_valids: aw/w/ar/b_rdy/r_rdy/rsp=%b required 000000",
                     {aw_valid, w_valid, ar_valid, b_ready, r_ready, rsp_valid});
        end
        n_vec++;
        if (rsp_rdata !== 32'h0 || rsp_resp !== 2'd0) begin
            n_err++;
            $display("FAIL reset_rsp: rdata=%h resp=%0d required 0/0", rsp_rdata, rsp_resp);
        end
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if (req_ready !== 1'b1) begin n_err++; $display("FAIL idle_req_ready: got %b required 1", req_ready); end
    endtask

    task automatic test_read_zero_wait();
        logic [DW-1:0] rd;
        logic [1:0]    rs;
        int            lat;
        int            ar0;
        ar0      = ar_hs;
        ar_ready = 1'b1;
        r_valid  = 1'b1;
        r_data   = 32'hDEADBEEF;
        r_resp   = 2'd0;
        issue(1'b0, 16'h0010, 32'h0, 4'h0);
        n_vec++;
        if (ar_valid !== 1'b1 || ar_addr !== 16'h0010) begin
            n_err++;
            $display("FAIL read_ar: valid=%b addr=%h required 1/0010", ar_valid, ar_addr);
        end
        n_vec++;
        if (ar_prot !== 3'b000 || ar_id !== 1'b0) begin
            n_err++;
            $display("FAIL read_ar_fixed: prot=%b id=%b required 000/0", ar_prot, ar_id);
        end
        wait_rsp(rd, rs, lat);
        n_vec++;
        if (lat !== 3) begin n_err++; $display("FAIL read_latency: got %0d required 3", lat); end
        n_vec++;
        if (rd !== 32'hDEADBEEF || rs !== 2'd0) begin
            n_err++;
            $display("FAIL read_rsp: rdata=%h resp=%0d required deadbeef/0", rd, rs);
        end
        n_vec++;
        if (ar_hs - ar0 !== 1) begin n_err++; $display("FAIL read_ar_count: got %0d required 1", ar_hs - ar0); end
    endtask

    task automatic test_write_aw_first();
        logic [DW-1:0] rd;
        logic [1:0]    rs;
        int            lat;
        int            aw0, w0;
        aw0      = aw_hs;
        w0       = w_hs;
        aw_ready = 1'b1;
        w_ready  = 1'b0;
        b_valid  = 1'b1;
        b_resp   = 2'd0;
        issue(1'b1, 16'h0004, 32'h0000_0041, 4'b0001);
        n_vec++;
        if (aw_valid !== 1'b1 || w_valid !== 1'b1 || aw_addr !== 16'h0004) begin
            n_err++;
            $display("FAIL wr_aw_first_start: aw=%b w=%b addr=%h required 1/1/0004", aw_valid, w_valid, aw_addr);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_vec++;
            if (w_valid !== 1'b1 || w_data !== 32'h41 || w_strb !== 4'b0001 || aw_valid !== 1'b0) begin
                n_err++;
                $display("FAIL wr_w_stall%0d: w_valid=%b data=%h strb=%b aw_valid=%b required 1/41/0001/0",
                         i, w_valid, w_data, w_strb, aw_valid);
            end
        end
        w_ready = 1'b1;
        wait_rsp(rd, rs, lat);
        n_vec++;
        if (rd !== 32'h0 || rs !== 2'd0) begin
            n_err++;
            $display("FAIL wr_aw_first_rsp: rdata=%h resp=%0d required 0/0", rd, rs);
        end
        n_vec++;
        if (aw_hs - aw0 !== 1 || w_hs - w0 !== 1) begin
            n_err++;
            $display("FAIL wr_aw_first_count: aw=%0d w=%0d required 1/1", aw_hs - aw0, w_hs - w0);
        end
    endtask

    task automatic test_write_w_first();
        logic [DW-1:0] rd;
        logic [1:0]    rs;
        int            lat;
        int            aw0, w0, b0;
        aw0      = aw_hs;
        w0       = w_hs;
        b0       = b_hs;
        aw_ready = 1'b0;
        w_ready  = 1'b1;
        issue(1'b1, 16'h0044, 32'h1234_5678, 4'b1111);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_vec++;
            if (aw_valid !== 1'b1 || aw_addr !== 16'h0044 || w_valid !== 1'b0 || b_ready !== 1'b0) begin
                n_err++;
                $display("FAIL wr_aw_stall%0d: aw=%b addr=%h w=%b b_ready=%b required 1/0044/0/0",
                         i, aw_valid, aw_addr, w_valid, b_ready);
            end
        end
        aw_ready = 1'b1;
        wait_rsp(rd, rs, lat);
        n_vec++;
        if (aw_hs - aw0 !== 1 || w_hs - w0 !== 1 || b_hs - b0 !== 1) begin
            n_err++;
            $display("FAIL wr_w_first_count: aw=%0d w=%0d b=%0d required 1/1/1",
                     aw_hs - aw0, w_hs - w0, b_hs - b0);
        end
    endtask

    task automatic test_write_simultaneous();
        logic [DW-1:0] rd;
        logic [1:0]    rs;
        int            lat;
        int            aw0, w0, b0;
        aw0      = aw_hs;
        w0       = w_hs;
        b0       = b_hs;
        aw_ready = 1'b1;
        w_ready  = 1'b1;
        issue(1'b1, 16'h0008, 32'hA5A5_0001, 4'b0011);
        n_vec++;
        if (w_data !== 32'hA5A5_0001 || w_strb !== 4'b0011) begin
            n_err++;
            $display("FAIL wr_sim_w: data=%h strb=%b required a5a50001/0011", w_data, w_strb);
        end
        wait_rsp(rd, rs, lat);
        n_vec++;
        if (lat !== 3) begin n_err++; $display("FAIL write_latency: got %0d required 3", lat); end
        n_vec++;
        if (aw_hs - aw0 !== 1 || w_hs - w0 !== 1 || b_hs - b0 !== 1) begin
            n_err++;
            $display("FAIL wr_sim_count: aw=%0d w=%0d b=%0d required 1/1/1",
                     aw_hs - aw0, w_hs - w0, b_hs - b0);
        end
    endtask

    task automatic test_errors();
        logic [DW-1:0] rd;
        logic [1:0]    rs;
        int            lat;
        r_data = 32'h1234_5678;
        r_resp = 2'd3;
        issue(1'b0, 16'h0100, 32'h0, 4'h0);
        wait_rsp(rd, rs, lat);
        n_vec++;
        if (rs !== 2'd3 || rd !== 32'h1234_5678) begin
            n_err++;
            $display("FAIL read_decerr: resp=%0d rdata=%h required 3/12345678", rs, rd);
        end
        b_resp = 2'd2;
        issue(1'b1, 16'h0104, 32'hFFFF_FFFF, 4'b1111);
        wait_rsp(rd, rs, lat);
        n_vec++;
        if (rs !== 2'd2 || rd !== 32'h0) begin
            n_err++;
            $display("FAIL write_slverr: resp=%0d rdata=%h required 2/0", rs, rd);
        end
        r_resp = 2'd0;
        b_resp = 2'd0;
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] rd;
        logic [1:0]    rs;
        int            lat;
        int            ar0;
        r_data    = 32'hCAFEF00D;
        rsp_ready = 1'b0;
        issue(1'b0, 16'h0020, 32'h0, 4'h0);
        for (int i = 0; i < 10 && !rsp_valid; i++) @(negedge clk);
        // Offer the next command while the response is still pending.
        ar0       = ar_hs;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 16'h0024;
        r_data    = 32'h0BAD_F00D;
        for (int i = 0; i < 10; i++) begin
            n_vec++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hCAFEF00D || req_ready !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold%0d: rsp_valid=%b rdata=%h req_ready=%b required 1/cafef00d/0",
                         i, rsp_valid, rsp_rdata, req_ready);
            end
            @(negedge clk);
        end
        n_vec++;
        if (ar_hs !== ar0) begin n_err++; $display("FAIL bp_no_accept: ar handshakes %0d required 0", ar_hs - ar0); end
        rsp_ready = 1'b1;
        @(negedge clk);
        n_vec++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_release: req_ready=%b rsp_valid=%b required 1/0", req_ready, rsp_valid);
        end
        @(negedge clk);
        req_valid = 1'b0;
        n_vec++;
        if (ar_valid !== 1'b1 || ar_addr !== 16'h0024) begin
            n_err++;
            $display("FAIL bp_next_ar: valid=%b addr=%h required 1/0024", ar_valid, ar_addr);
        end
        wait_rsp(rd, rs, lat);
        n_vec++;
        if (rd !== 32'h0BAD_F00D) begin n_err++; $display("FAIL bp_next_rsp: rdata=%h required 0badf00d", rd); end
    endtask

    task automatic test_reset_mid_write();
        logic [DW-1:0] rd;
        logic [1:0]    rs;
        int            lat;
        aw_ready = 1'b0;
        w_ready  = 1'b0;
        issue(1'b1, 16'h0030, 32'h7777_7777, 4'b1111);
        n_vec++;
        if (aw_valid !== 1'b1 || w_valid !== 1'b1) begin
            n_err++;
            $display("FAIL mid_wr_start: aw=%b w=%b required 1/1", aw_valid, w_valid);
        end
        rst = 1'b1;
        #1;
        n_vec++;
        if (req_ready !== 1'b0) begin n_err++; $display("FAIL mid_rst_req_ready: got %b required 0", req_ready); end
        @(negedge clk);
        n_vec++;
        if ({aw_valid, w_valid, ar_valid, b_ready, r_ready, rsp_valid} !== 6'b0) begin
            n_err++;
            $display("FAIL mid_rst_valids: aw/w/ar/b_rdy/r_rdy/rsp=%b required 000000",
                     {aw_valid, w_valid, ar_valid, b_ready, r_ready, rsp_valid});
        end
        rst = 1'b0;
        #1;
        n_vec++;
        if (req_ready !== 1'b1) begin n_err++; $display("FAIL mid_rst_idle: req_ready=%b required 1", req_ready); end
        aw_ready = 1'b1;
        w_ready  = 1'b1;
        r_data   = 32'h55AA_55AA;
        @(negedge clk);
        issue(1'b0, 16'h0034, 32'h0, 4'h0);
        wait_rsp(rd, rs, lat);
        n_vec++;
        if (rd !== 32'h55AA_55AA || rs !== 2'd0 || lat !== 3) begin
            n_err++;
            $display("FAIL post_rst_read: rdata=%h resp=%0d lat=%0d required 55aa55aa/0/3", rd, rs, lat);
        end
    endtask

    // ------------------------------------------------------------------ main
    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_strb  = '0;
        rsp_ready = 1'b1;
        aw_ready  = 1'b0;
        w_ready   = 1'b0;
        b_valid   = 1'b0;
        b_id      = 1'b1;
        b_resp    = 2'd0;
        ar_ready  = 1'b0;
        r_valid   = 1'b0;
        r_id      = 1'b1;
        r_data    = '0;
        r_resp    = 2'd0;

        test_reset();
        test_read_zero_wait();
        test_write_aw_first();
        test_write_w_first();
        test_write_simultaneous();
        test_errors();
        test_backpressure();
        test_reset_mid_write();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d vectors applied", n_vec);
        $fatal(1);
    end

endmodule
